// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter with valid/ready handshakes and a bounded burst per grant.
// Drives the downstream 2:1 selector from a registered grant and holds the accepted beat in a one-entry output register.
module mux2_rr_arbiter #(
  parameter int WIDTH = 2,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2,
  input  logic             in2_valid,
  output logic             in2_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  state_t     state;
  logic       last2;  // 1 when source 2 was the last one served
  logic [3:0] cnt;
  logic       load_en;
  logic       xfer1;
  logic       xfer2;
  logic       burst_end;

  assign load_en   = !out_valid || out_ready;
  // Readies are held low while reset is asserted so no beat is offered to a block being cleared.
  assign in1_ready = rst_n && (state == GNT1) && load_en;
  assign in2_ready = rst_n && (state == GNT2) && load_en;
  assign xfer1     = in1_valid && in1_ready;
  assign xfer2     = in2_valid && in2_ready;
  assign burst_end = (cnt == CNT_LAST);

  // NOTE: every register here is sequential state, so only non-blocking assignments are used
  // in this block; blocking ones would let later statements see half-updated values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out1      <= '0;
      cnt       <= '0;
      last2     <= 1'b1;
    end else begin
      if (xfer1) begin
        out1      <= in1;
        out_valid <= 1'b1;
      end else if (xfer2) begin
        out1      <= in2;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (in1_valid && (!in2_valid || last2)) begin
            state <= GNT1;
            sel   <= 1'b1;
          end else if (in2_valid) begin
            state <= GNT2;
            sel   <= 1'b0;
          end
        end

        GNT1: begin
          if (!in1_valid) begin
            state <= in2_valid ? GNT2 : IDLE;
            if (in2_valid) sel <= 1'b0;
            cnt   <= '0;
            last2 <= 1'b0;
          end else if (xfer1) begin
            if (burst_end && in2_valid) begin
              state <= GNT2;
              sel   <= 1'b0;
              cnt   <= '0;
              last2 <= 1'b0;
            end else if (burst_end) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        GNT2: begin
          if (!in2_valid) begin
            state <= in1_valid ? GNT1 : IDLE;
            if (in1_valid) sel <= 1'b1;
            cnt   <= '0;
            last2 <= 1'b1;
          end else if (xfer2) begin
            if (burst_end && in1_valid) begin
              state <= GNT1;
              sel   <= 1'b1;
              cnt   <= '0;
              last2 <= 1'b1;
            end else if (burst_end) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: hand-derived vector table, a single-source stream, then random
// traffic compared against a transaction-level owner/beat-count model.
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 2;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in1, in2, out1;
  logic             in1_valid, in2_valid, in1_ready, in2_ready;
  logic             sel, out_valid, out_ready;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in2(in2), .in2_valid(in2_valid), .in2_ready(in2_ready),
    .sel(sel), .out1(out1), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic v1, input int d1, input logic v2, input int d2,
                       input logic ordy);
    rst_n     = r;
    in1_valid = v1;
    in1       = WIDTH'(d1);
    in2_valid = v2;
    in2       = WIDTH'(d2);
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r, v1, v2, ordy;
    int         d1, d2;
    logic       sel, ov;
    int         out;
    logic       r1, r2;
  } vec_t;

  function automatic vec_t mk(logic r, logic v1, int d1, logic v2, int d2, logic ordy,
                              logic s, logic ov, int o, logic r1, logic r2);
    vec_t t;
    t.r = r; t.v1 = v1; t.d1 = d1; t.v2 = v2; t.d2 = d2; t.ordy = ordy;
    t.sel = s; t.ov = ov; t.out = o; t.r1 = r1; t.r2 = r2;
    return t;
  endfunction

  // ---------------- reference model ----------------
  // Owner 0 means nobody holds the path; beats counts transfers within the current grant.
  int m_owner, m_beats, m_last, m_sel, m_out, m_ov;

  function automatic int m_ready(int n, logic rstn, logic ordy);
    return (rstn && m_owner == n && (m_ov == 0 || ordy)) ? 1 : 0;
  endfunction

  task automatic m_step(input logic rstn, input logic v1, input logic v2, input int d1,
                        input int d2, input logic ordy);
    int vld[1:2];
    int dat[1:2];
    int nxt, oth;
    bit acc;
    if (!rstn) begin
      m_owner = 0; m_beats = 0; m_last = 2; m_sel = 0; m_out = 0; m_ov = 0;
      return;
    end
    vld[1] = int'(v1); vld[2] = int'(v2);
    dat[1] = d1;       dat[2] = d2;
    acc = (m_owner != 0) && (vld[m_owner] != 0) && (m_ready(m_owner, rstn, ordy) == 1);
    if (acc) begin
      m_out = dat[m_owner];
      m_ov  = 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    nxt = m_owner;
    if (m_owner == 0) begin
      if (vld[1] != 0 && vld[2] != 0) nxt = 3 - m_last;
      else if (vld[1] != 0)           nxt = 1;
      else if (vld[2] != 0)           nxt = 2;
    end else begin
      oth = 3 - m_owner;
      if (vld[m_owner] == 0) nxt = (vld[oth] != 0) ? oth : 0;
      else if (acc) begin
        m_beats++;
        if (m_beats == BURST) begin
          if (vld[oth] != 0) nxt = oth;
          else m_beats = 0;
        end
      end
    end
    if (nxt != m_owner) begin
      if (m_owner != 0) m_last = m_owner;
      m_beats = 0;
      if (nxt != 0) m_sel = (nxt == 1) ? 1 : 0;
      m_owner = nxt;
    end
  endtask

  initial begin
    vec_t tbl[$];
    int   dat[6];
    logic v1, v2, ordy, r;
    int   d1, d2;

    // reset, contention, backpressure, owner drop, idle return, mid-burst reset
    tbl.push_back(mk(0,1,1,1,2,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,2,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,2,1, 1,0,0,1,0));
    tbl.push_back(mk(1,1,1,1,2,1, 1,1,1,1,0));
    tbl.push_back(mk(1,1,1,1,2,1, 1,1,1,1,0));
    tbl.push_back(mk(1,1,1,1,2,1, 1,1,1,1,0));
    tbl.push_back(mk(1,1,1,1,2,1, 0,1,1,0,1));
    tbl.push_back(mk(1,1,1,1,2,1, 0,1,2,0,1));
    tbl.push_back(mk(1,1,1,1,2,1, 0,1,2,0,1));
    tbl.push_back(mk(1,1,1,1,2,1, 0,1,2,0,1));
    tbl.push_back(mk(1,1,1,1,2,1, 1,1,2,1,0));
    tbl.push_back(mk(1,1,3,1,2,0, 1,1,1,0,0));
    tbl.push_back(mk(1,1,3,1,2,0, 1,1,1,0,0));
    tbl.push_back(mk(1,1,3,1,2,0, 1,1,1,0,0));
    tbl.push_back(mk(1,1,3,1,2,1, 1,1,1,1,0));
    tbl.push_back(mk(1,1,0,1,2,1, 1,1,3,1,0));
    tbl.push_back(mk(1,0,0,1,2,1, 1,1,0,1,0));
    tbl.push_back(mk(1,0,0,1,1,1, 0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,1,1, 0,1,1,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,1,0,0));
    tbl.push_back(mk(1,1,2,1,0,1, 0,0,1,0,0));
    tbl.push_back(mk(1,1,2,0,0,1, 1,0,1,1,0));
    tbl.push_back(mk(1,1,3,0,0,1, 1,1,2,1,0));
    tbl.push_back(mk(0,1,1,0,0,1, 1,1,3,0,0));
    tbl.push_back(mk(1,1,1,1,2,1, 0,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,2,1, 1,0,0,1,0));
    tbl.push_back(mk(1,1,1,1,2,1, 1,1,1,1,0));

    drive(0, 1, 1, 1, 2, 1);
    next_cycle();
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d sel", i),       32'(sel),       32'(tbl[i].sel));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("vec%0d out1", i),      32'(out1),      32'(tbl[i].out));
      check($sformatf("vec%0d in1_ready", i), 32'(in1_ready), 32'(tbl[i].r1));
      check($sformatf("vec%0d in2_ready", i), 32'(in2_ready), 32'(tbl[i].r2));
      next_cycle();
    end

    // single source 2 stream, longer than one burst: no switch, data in order
    dat = '{3, 2, 1, 0, 3, 2};
    drive(0, 0, 0, 0, 0, 1);
    next_cycle();
    drive(1, 0, 0, 1, dat[0], 1);
    @(negedge clk);
    check("single idle in2_ready", 32'(in2_ready), 32'd0);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 1, dat[k], 1);
      @(negedge clk);
      check($sformatf("single%0d in2_ready", k), 32'(in2_ready), 32'd1);
      check($sformatf("single%0d sel", k), 32'(sel), 32'd0);
      if (k > 0) check($sformatf("single%0d out1", k), 32'(out1), 32'(dat[k-1]));
      next_cycle();
    end
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("single last out1", 32'(out1), 32'(dat[5]));
    check("single last out_valid", 32'(out_valid), 32'd1);
    next_cycle();

    // randomized traffic against the model
    drive(0, 0, 0, 0, 0, 1);
    m_step(0, 0, 0, 0, 0, 1);
    next_cycle();
    v1 = 0; v2 = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) v1 = ~v1;
      if ($urandom_range(5) == 0) v2 = ~v2;
      ordy = ($urandom_range(3) != 0);
      r    = ($urandom_range(199) != 0);
      d1   = int'($urandom_range(3));
      d2   = int'($urandom_range(3));
      drive(r, v1, d1, v2, d2, ordy);
      @(negedge clk);
      check("rand sel",       32'(sel),       32'(m_sel));
      check("rand out_valid", 32'(out_valid), 32'(m_ov));
      check("rand out1",      32'(out1),      32'(m_out));
      check("rand in1_ready", 32'(in1_ready), 32'(m_ready(1, r, ordy)));
      check("rand in2_ready", 32'(in2_ready), 32'(m_ready(2, r, ordy)));
      m_step(r, v1, v2, d1, d2, ordy);
      next_cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
